// File: rtl/matrix_seq_ctrl_pkg.sv
// Shared types and default sizing for the matrix processor control sequencer.
package mp_pkg;

    localparam int unsigned MP_DIM_DEF  = 4;
    localparam int unsigned MP_WI_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_MAT = 3'd1,
        ST_LOAD_VEC = 3'd2,
        ST_COMPUTE  = 3'd3,
        ST_WRITE    = 3'd4
    } mp_state_t;

endpackage

// File: rtl/matrix_seq_ctrl_if.sv
// Command, operand-read, FMA and writeback signals between the sequencer and its datapath.
interface matrix_seq_ctrl_if
    import mp_pkg::*;
#(
    parameter int unsigned DIM  = MP_DIM_DEF,
    parameter int unsigned WI_W = MP_WI_W_DEF
);
    localparam int unsigned IDX_W = $clog2(DIM * DIM);
    localparam int unsigned COL_W = $clog2(DIM);

    logic             start;
    logic [WI_W-1:0]  wi_count;
    logic             abort;
    logic             rd_req;
    logic             rd_sel;
    logic [IDX_W-1:0] rd_idx;
    logic [WI_W-1:0]  rd_vec;
    logic             rd_ack;
    logic             load_matrix;
    logic             load_vector;
    logic             fma_en;
    logic [COL_W-1:0] fma_col;
    logic             acc_clear;
    logic             wr_valid;
    logic             wr_ready;
    logic             busy;
    logic             done;

    modport master (
        input  start, wi_count, abort, rd_ack, wr_ready,
        output rd_req, rd_sel, rd_idx, rd_vec, load_matrix, load_vector,
               fma_en, fma_col, acc_clear, wr_valid, busy, done
    );

    modport slave (
        output start, wi_count, abort, rd_ack, wr_ready,
        input  rd_req, rd_sel, rd_idx, rd_vec, load_matrix, load_vector,
               fma_en, fma_col, acc_clear, wr_valid, busy, done
    );

endinterface

// File: rtl/matrix_seq_ctrl_step_counter.sv
// Wrapping step counter 0..MAX with synchronous clear (priority) and enable.
module mp_step_counter
    import mp_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             term_o
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == MAX_V) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == MAX_V);

endmodule

// File: rtl/matrix_seq_ctrl.sv
// DIM x DIM matrix-vector job sequencer: loads the matrix once, then per work item
// loads a vector, steps the FMA array DIM times and hands the result to writeback.
module matrix_seq_ctrl
    import mp_pkg::*;
#(
    parameter int unsigned DIM  = MP_DIM_DEF,
    parameter int unsigned WI_W = MP_WI_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    matrix_seq_ctrl_if.master bus
);
    localparam int unsigned      IDX_W    = $clog2(DIM * DIM);
    localparam int unsigned      COL_W    = $clog2(DIM);
    localparam logic [IDX_W-1:0] VEC_LAST = IDX_W'(DIM - 1);

    mp_state_t       state_q, state_d;
    logic [WI_W-1:0] remaining_q, remaining_d;
    logic [WI_W-1:0] rd_vec_q, rd_vec_d;
    logic            done_q, done_d;

    logic             rd_req, rd_sel, fma_en, wr_valid;
    logic             abort_act, rd_hs, wr_hs;
    logic [IDX_W-1:0] idx;
    logic             idx_term, idx_clr;
    logic [COL_W-1:0] col;
    logic             col_term, col_clr;

    always_comb begin
        rd_req   = 1'b0;
        rd_sel   = 1'b0;
        fma_en   = 1'b0;
        wr_valid = 1'b0;
        case (state_q)
            ST_LOAD_MAT: rd_req = 1'b1;
            ST_LOAD_VEC: begin
                rd_req = 1'b1;
                rd_sel = 1'b1;
            end
            ST_COMPUTE:  fma_en   = 1'b1;
            ST_WRITE:    wr_valid = 1'b1;
            default: ;
        endcase
    end

    assign abort_act = bus.abort & (state_q != ST_IDLE);
    assign rd_hs     = rd_req & bus.rd_ack;
    assign wr_hs     = wr_valid & bus.wr_ready;

    // The matrix pass wraps the index to 0 on its own; the vector pass ends early and must clear it.
    assign idx_clr = abort_act | ~rd_req | (rd_sel & rd_hs & (idx == VEC_LAST));
    assign col_clr = abort_act | ~fma_en;

    mp_step_counter #(
        .WIDTH (IDX_W),
        .MAX   (DIM * DIM - 1)
    ) u_idx_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (idx_clr),
        .en_i    (rd_hs),
        .count_o (idx),
        .term_o  (idx_term)
    );

    mp_step_counter #(
        .WIDTH (COL_W),
        .MAX   (DIM - 1)
    ) u_col_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (col_clr),
        .en_i    (fma_en),
        .count_o (col),
        .term_o  (col_term)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rd_vec_d    = rd_vec_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.wi_count;
                    rd_vec_d    = '0;
                    if (bus.wi_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD_MAT;
                    end
                end
            end
            ST_LOAD_MAT: if (rd_hs && idx_term) state_d = ST_LOAD_VEC;
            ST_LOAD_VEC: if (rd_hs && (idx == VEC_LAST)) state_d = ST_COMPUTE;
            ST_COMPUTE:  if (col_term) state_d = ST_WRITE;
            ST_WRITE: begin
                if (wr_hs) begin
                    remaining_d = remaining_q - WI_W'(1);
                    rd_vec_d    = rd_vec_q + WI_W'(1);
                    if (remaining_q == WI_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD_VEC;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_act) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
            rd_vec_d    = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            rd_vec_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rd_vec_q    <= rd_vec_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_req      = rd_req;
    assign bus.rd_sel      = rd_sel;
    assign bus.rd_idx      = idx;
    assign bus.rd_vec      = rd_vec_q;
    assign bus.load_matrix = rd_hs & ~rd_sel;
    assign bus.load_vector = rd_hs & rd_sel;
    assign bus.fma_en      = fma_en;
    assign bus.fma_col     = col;
    assign bus.acc_clear   = fma_en & (col == '0);
    assign bus.wr_valid    = wr_valid;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Directed bench for matrix_seq_ctrl at DIM=4: job flow, stalls, abort and reset.
module tb_matrix_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    matrix_seq_ctrl_if #(.DIM(4), .WI_W(16)) ifc ();

    matrix_seq_ctrl #(.DIM(4), .WI_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc, done_cyc, n_lm, n_lv, n_fma, n_clr, clr_err, n_wv, n_wr;
    int n_busy, n_rdreq, n_done, mat_next, mat_err, done_busy_err, n_vec_seen;
    logic [15:0] vec_seen [0:3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mon_reset();
        cyc = 0; done_cyc = -1; n_lm = 0; n_lv = 0; n_fma = 0; n_clr = 0; clr_err = 0;
        n_wv = 0; n_wr = 0; n_busy = 0; n_rdreq = 0; n_done = 0; mat_next = 0;
        mat_err = 0; done_busy_err = 0; n_vec_seen = 0;
        for (int i = 0; i < 4; i++) vec_seen[i] = 16'hFFFF;
    endtask

    // Samples the cycle preceding the next rising edge, then returns at the following negedge.
    task automatic cycle();
        #1;
        if (ifc.load_matrix) begin
            if (32'(ifc.rd_idx) != mat_next) mat_err++;
            mat_next++;
            n_lm++;
        end
        if (ifc.load_vector) begin
            n_lv++;
            if (ifc.rd_idx == 0 && n_vec_seen < 4) begin
                vec_seen[n_vec_seen] = ifc.rd_vec;
                n_vec_seen++;
            end
        end
        if (ifc.fma_en) n_fma++;
        if (ifc.acc_clear) begin
            n_clr++;
            if (ifc.fma_col != 0) clr_err++;
        end
        if (ifc.wr_valid) n_wv++;
        if (ifc.wr_valid && ifc.wr_ready) n_wr++;
        if (ifc.busy) n_busy++;
        if (ifc.rd_req) n_rdreq++;
        if (ifc.done) begin
            n_done++;
            if (ifc.busy) done_busy_err++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_job(input logic [15:0] wi);
        mon_reset();
        ifc.start    = 1'b1;
        ifc.wi_count = wi;
        cycle();
        ifc.start    = 1'b0;
    endtask

    task automatic run_to_done(input int max);
        for (int g = 0; g < max && n_done == 0; g++) cycle();
    endtask

    initial begin
        ifc.start = 1'b0; ifc.wi_count = '0; ifc.abort = 1'b0;
        ifc.rd_ack = 1'b0; ifc.wr_ready = 1'b0;
        mon_reset();
        repeat (2) @(negedge clk);

        check("rst_busy",   32'(ifc.busy), 0);
        check("rst_rd_req", 32'(ifc.rd_req), 0);
        check("rst_rd_idx", 32'(ifc.rd_idx), 0);
        check("rst_rd_vec", 32'(ifc.rd_vec), 0);
        check("rst_fma",    32'(ifc.fma_en) | 32'(ifc.fma_col) | 32'(ifc.acc_clear), 0);
        check("rst_wr_done", 32'(ifc.wr_valid) | 32'(ifc.done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full job, two work items, no stalls.
        ifc.rd_ack = 1'b1; ifc.wr_ready = 1'b1;
        start_job(16'd2);
        check("job_busy_n1", 32'(ifc.busy) & 32'(ifc.rd_req), 1);
        run_to_done(60);
        cycle();
        check("job_done_cyc", 32'(done_cyc), 35);
        check("job_done_cnt", 32'(n_done), 1);
        check("job_done_busy", 32'(done_busy_err), 0);
        check("job_lm", 32'(n_lm), 16);
        check("job_lm_order", 32'(mat_err), 0);
        check("job_lv", 32'(n_lv), 8);
        check("job_fma", 32'(n_fma), 8);
        check("job_clr", 32'(n_clr), 2);
        check("job_clr_col", 32'(clr_err), 0);
        check("job_wr", 32'(n_wr), 2);
        check("job_busy_cycles", 32'(n_busy), 34);
        check("job_vec0", 32'(vec_seen[0]), 0);
        check("job_vec1", 32'(vec_seen[1]), 1);

        // Zero work items: immediate done, never busy.
        start_job(16'd0);
        repeat (4) cycle();
        check("zero_done_cyc", 32'(done_cyc), 1);
        check("zero_done_cnt", 32'(n_done), 1);
        check("zero_busy", 32'(n_busy), 0);
        check("zero_rd_req", 32'(n_rdreq), 0);

        // rd_ack toggling during the matrix load.
        ifc.rd_ack = 1'b0;
        start_job(16'd1);
        cycle();
        ifc.rd_ack = 1'b1;
        #1;
        check("stall_idx_hold", 32'(ifc.rd_idx), 0);
        check("stall_lm_on_ack", 32'(ifc.load_matrix), 1);
        cycle();
        check("stall_idx_adv", 32'(ifc.rd_idx), 1);
        for (int k = 0; k < 100 && n_lm < 16; k++) begin
            ifc.rd_ack = k[0];
            cycle();
        end
        ifc.rd_ack = 1'b1;
        run_to_done(60);
        check("stall_lm", 32'(n_lm), 16);
        check("stall_lm_order", 32'(mat_err), 0);
        check("stall_done", 32'(n_done), 1);

        // Writeback back-pressure: wr_ready low for 5 WRITE cycles.
        ifc.wr_ready = 1'b0;
        start_job(16'd1);
        for (int g = 0; g < 100 && n_wv == 0; g++) cycle();
        repeat (4) cycle();
        check("bp_valid_held", 32'(ifc.wr_valid), 1);
        check("bp_vec_held", 32'(ifc.rd_vec), 0);
        check("bp_no_done", 32'(n_done), 0);
        ifc.wr_ready = 1'b1;
        cycle();
        cycle();
        check("bp_valid_cycles", 32'(n_wv), 6);
        check("bp_wr", 32'(n_wr), 1);
        check("bp_done", 32'(n_done), 1);

        // Abort at fma_col = 2.
        start_job(16'd1);
        repeat (22) cycle();
        ifc.abort = 1'b1;
        #1;
        check("abort_at_col2", {30'd0, 1'(ifc.fma_en), 1'(ifc.fma_col == 2)}, 3);
        cycle();
        ifc.abort = 1'b0;
        #1;
        check("abort_busy", 32'(ifc.busy), 0);
        check("abort_outs", 32'(ifc.rd_req) | 32'(ifc.fma_en) | 32'(ifc.wr_valid)
                            | 32'(ifc.acc_clear) | 32'(ifc.fma_col) | 32'(ifc.rd_idx), 0);
        check("abort_rd_vec", 32'(ifc.rd_vec), 0);
        repeat (3) cycle();
        check("abort_no_done", 32'(n_done), 0);
        start_job(16'd1);
        run_to_done(60);
        check("abort_restart_lm", 32'(n_lm), 16);
        check("abort_restart_done", 32'(done_cyc), 26);

        // Asynchronous reset in LOAD_VEC, then start-while-busy is ignored.
        start_job(16'd2);
        repeat (17) cycle();
        check("rstmid_in_lv", 32'(ifc.rd_sel), 1);
        rst = 1'b1;
        #1;
        check("rstmid_busy", 32'(ifc.busy), 0);
        check("rstmid_outs", 32'(ifc.rd_req) | 32'(ifc.rd_sel) | 32'(ifc.load_vector)
                             | 32'(ifc.rd_idx) | 32'(ifc.done), 0);
        @(negedge clk);
        rst = 1'b0;
        start_job(16'd1);
        repeat (5) cycle();
        ifc.start = 1'b1; ifc.wi_count = 16'd3;
        cycle();
        ifc.start = 1'b0; ifc.wi_count = 16'd0;
        run_to_done(100);
        cycle();
        check("busy_start_done", 32'(done_cyc), 26);
        check("busy_start_wr", 32'(n_wr), 1);
        check("busy_start_lm", 32'(n_lm), 16);
        check("busy_start_idle", 32'(ifc.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matrix_seq_ctrl.md
# matrix_seq_ctrl

Parametrised control sequencer for the matrix processor datapath. Generalises the fixed 4x4 load/compute controller to a DIM x DIM matrix and adds explicit read and write handshakes, a latched work-item count, abort, and busy/done status. It sits between the command front end and the matrix/vector register files plus FMA array, and drives every load, compute and writeback strobe.

## Interface
- DIM, 4: matrix dimension; DIM >= 2.
- WI_W, 16: work-item counter width.
- IDX_W, $clog2(DIM*DIM): element index width (derived, not overridden).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- wi_count  in  WI_W  number of vectors to process; latched on accepted start.
- abort  in  1  synchronous cancel; returns to IDLE next edge, no done.
- rd_req  out  1  read request to operand memory.
- rd_sel  out  1  0 = matrix element, 1 = vector element.
- rd_idx  out  IDX_W  element index (matrix: row*DIM+col; vector: 0..DIM-1).
- rd_vec  out  WI_W  current work-item number (vector base select).
- rd_ack  in  1  memory accepts request and returns data in the same cycle.
- load_matrix  out  1  write matrix reg[rd_idx]; equals rd_req & rd_ack & ~rd_sel.
- load_vector  out  1  write vector reg[rd_idx]; equals rd_req & rd_ack & rd_sel.
- fma_en  out  1  FMA array step enable.
- fma_col  out  $clog2(DIM)  column/vector element being accumulated.
- acc_clear  out  1  clear accumulators before first FMA step (with fma_col = 0).
- wr_valid  out  1  result vector ready for writeback.
- wr_ready  in  1  writeback sink accepts.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on job completion.

## Operation
- States: IDLE, LOAD_MAT, LOAD_VEC, COMPUTE, WRITE.
- IDLE: start=1 latches wi_count into remaining, clears rd_vec; if wi_count = 0, done pulses next cycle, stays IDLE; else -> LOAD_MAT.
- LOAD_MAT: rd_req=1, rd_sel=0. idx advances only on rd_ack; on rd_ack at idx = DIM*DIM-1, idx clears, -> LOAD_VEC. Matrix loaded once per job.
- LOAD_VEC: rd_req=1, rd_sel=1. idx advances on rd_ack; on rd_ack at idx = DIM-1, idx clears, -> COMPUTE.
- COMPUTE: fma_en=1 for exactly DIM cycles, fma_col = 0..DIM-1; acc_clear=1 only when fma_col=0; after fma_col = DIM-1 -> WRITE.
- WRITE: wr_valid=1 held until wr_ready. On handshake: remaining decrements, rd_vec increments; if remaining was 1 -> done pulse, IDLE; else -> LOAD_VEC.
- abort in any non-IDLE state: -> IDLE, counters cleared, no done; abort in IDLE ignored. abort wins over simultaneous rd_ack/wr_ready/transition.
- start while busy ignored; wi_count not re-sampled mid-job.
- Unused/illegal state encodings -> IDLE.
- Outputs combinational from registered state and counters only (no input-to-output paths except load_matrix/load_vector through rd_ack).

## Timing
- Reset: state IDLE, all counters 0; rd_req, rd_sel, rd_idx, rd_vec, load_*, fma_en, fma_col, acc_clear, wr_valid, busy, done all 0.
- Reset mid-job aborts immediately (asynchronous); no done.
- start at edge N -> busy and rd_req high from cycle N+1.
- Per vector with rd_ack always high: DIM load + DIM compute + 1 write cycle (wr_ready high) = 2*DIM+1 cycles; matrix costs DIM*DIM cycles once.
- rd_req stalls (held, idx unchanged) while rd_ack=0; wr_valid held while wr_ready=0.
- done asserted in the cycle after final wr handshake, coincident with busy=0.

## Structure
- Package mp_pkg: state enum mp_state_t, default DIM/WI_W constants.
- Sub-module mp_step_counter (parameter WIDTH, MAX): clear, enable, count, terminal flag; instanced for element index and fma_col.
- remaining/rd_vec counters inline.

## Test plan
- DIM=4, wi_count=2, rd_ack=wr_ready=1: 16 matrix loads, then 2x(4 vector loads, 4 fma, 1 write); done at cycle 16+2*9+1 after start; rd_vec 0 then 1.
- wi_count=0: no rd_req, done pulses one cycle after start, busy never high.
- rd_ack toggling 1/0 during LOAD_MAT: rd_idx holds on 0, exactly 16 load_matrix pulses with indices 0..15 in order.
- wr_ready low 5 cycles in WRITE: wr_valid held 6 cycles, remaining unchanged until handshake.
- abort during COMPUTE (fma_col=2): next cycle IDLE, all outputs 0, no done; new start re-loads matrix.
- rst asserted mid LOAD_VEC: outputs 0 immediately; start during busy ignored with wi_count change not taking effect.
